apu_i2s_tx: RTL and testbench
=============================

# apu_i2s_tx

Audio output stage of the NES APU path. Consumes the unsigned mixer sample stream, one sample per `clk`, and box-filter decimates it to one sample per I2S frame. It converts the result to two's complement and serialises it as a mono-duplicated 16-bit stereo I2S stream for an external DAC. It generates its own BCLK and LRCLK from `clk`, acting as I2S bus master.

## Interface
- `AUDIO_DEPTH`, 16: width of mixer input and of each I2S data word.
- `BCLK_LOG2`, 2: BCLK half-period is 2^BCLK_LOG2 `clk` cycles. One frame is 64 BCLK periods, i.e. 2^(BCLK_LOG2+7) `clk` cycles.

- `clk`  in  1  system clock (APU/CPU clock domain).
- `rst_n`  in  1  asynchronous active-low reset.
- `mix`  in  AUDIO_DEPTH  unsigned mixer sample, new value every `clk`.
- `enable`  in  1  1 = pass audio; 0 = latch digital silence (0x0000) at each frame boundary.
- `i2s_bclk`  out  1  bit clock, registered.
- `i2s_lrclk`  out  1  word select, registered; 0 = left slot, 1 = right slot.
- `i2s_sdata`  out  1  serial data, registered, MSB first.
- `sample_strobe`  out  1  one-cycle pulse when a new decimated sample is latched.

## Operation
- **Frame counter `cnt`:** N = BCLK_LOG2+7 bits, free-running, increments every `clk`, wraps at 2^N−1 → 0.
- **Accumulator `acc`:** AUDIO_DEPTH+N bits, unsigned.
  - When `cnt` ≠ max: `acc <= acc + mix`.
  - When `cnt` = max: `sum = acc + mix`, then `acc <= 0`.
  - Each sum therefore covers exactly 2^N consecutive `mix` samples, with no gaps or overlaps. Overflow is impossible by width.
- **Average:** `avg = sum[AUDIO_DEPTH+N-1 : N]`, a floor divide by 2^N.
- **Conversion to signed:** `sample_q <= enable ? {~avg[MSB], avg[MSB-1:0]} : 0`. The MSB inversion is offset-binary to two's-complement.
  - Updated only at `cnt` = max.
  - Held for the entire following frame; both slots carry the same value.
- **`sample_strobe`:** registered 1 on the edge where `sample_q` updates, 0 otherwise.
- **Serialiser**, with fields of `cnt`:
  - Bit index `b = cnt[N-1 : BCLK_LOG2+1]` (0..63).
  - Slot position `p = b[4:0]`.
  - Registered outputs at each edge:
    - `i2s_bclk <= cnt[BCLK_LOG2]`
    - `i2s_lrclk <= b[5]`
    - `i2s_sdata <= (1 ≤ p ≤ AUDIO_DEPTH) ? sample_q[AUDIO_DEPTH−p] : 0`
- **Resulting bus format:** standard I2S.
  - Data changes on BCLK falling edges and is stable at rising edges.
  - MSB is delayed one BCLK after the LRCLK transition.
  - Slots are 32 bits; bits after the LSB are zero.
- **`enable` changes** take effect only at the next frame boundary; there is no mid-frame glitch.

## Timing
- **Reset (`rst_n` low, asynchronous):** `cnt`, `acc` and `sample_q` are 0.
  - All outputs are 0: `i2s_bclk`, `i2s_lrclk`, `i2s_sdata`, `sample_strobe`.
- **Reset release:** first `cnt` increment on the first `clk` edge after deassertion.
  - First `sample_strobe` occurs 2^N cycles later.
  - The first frame transmits `sample_q` = 0.
- **Reset mid-frame:** the partial accumulation is discarded, the bus restarts at the left slot, bit 0; no partial word is emitted afterwards.
- **Output register latency:** outputs lag `cnt` by one cycle. The register reading `cnt` = 0 also sees the newly latched `sample_q`, so frame k carries the average of frame k−1's inputs.
- **Latency:** input sample to first transmitted bit is at most 2^N + 2^(BCLK_LOG2+1) + 1 cycles.
- **LRCLK:** toggles coincident with a BCLK falling edge, every 32 BCLK periods.
- **Throughput:** one sample per 2^N cycles (≈41.9 kHz at 21.477 MHz with the default `BCLK_LOG2`).

## Test plan
- **Reset values:** hold `rst_n` low with `mix` = 0xFFFF and `enable` = 1 → all outputs are 0. Release → `sample_strobe` first pulses exactly 2^N cycles later.
- **Conversion extremes**, constant `mix`, `BCLK_LOG2` = 0, after 2 frames:
  - 0x8000 → `sample_q` 0x0000.
  - 0xFFFF → 0x7FFF.
  - 0x0000 → 0x8000.
- **Box filter:** `mix` alternates 0x0000/0x2000 each cycle → `avg` 0x1000, `sample_q` 0x9000. A single-cycle 0xFFFF spike on a 0 baseline with `BCLK_LOG2` = 0 → `avg` 0x01FF.
- **Bit-level framing:** force `avg` such that `sample_q` = 0xA5C3. After LRCLK falls, the left slot decodes on BCLK rising edges as:
  - one 0 bit (delay slot);
  - then 1010 0101 1100 0011;
  - then 15 zeros.
  - The right slot after LRCLK rises is identical.
  - BCLK period is 2^(BCLK_LOG2+1) cycles; LRCLK period is 64 BCLK.
- **`enable` gating:** deassert `enable` mid-frame with `mix` = 0xFFFF.
  - The current frame still transmits 0x7FFF.
  - The next frame transmits 0x0000.
  - Reasserting `enable` restores 0x7FFF one frame later.
- **Asynchronous reset mid-frame:** pulse `rst_n` low at bit index 20 for less than one `clk` period, away from edges. All outputs go 0 immediately, without waiting for a `clk` edge. After release, the left slot restarts with `sample_q` = 0 and the next strobe follows 2^N cycles later.

Source files
------------

// File: rtl/apu_i2s_tx.sv
// apu_i2s_tx: box-filter decimator and I2S master transmitter
// for the APU mixer stream; mono sample duplicated in both slots.
module apu_i2s_tx #(
  parameter int AUDIO_DEPTH = 16,
  parameter int BCLK_LOG2   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AUDIO_DEPTH-1:0] mix,
  input  logic                   enable,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_sdata,
  output logic                   sample_strobe
);

  localparam int N  = BCLK_LOG2 + 7;
  localparam int AW = AUDIO_DEPTH + N;
  localparam logic [5:0] DW = 6'(AUDIO_DEPTH);

  logic [N-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [AW-1:0]          sum;
  logic [AUDIO_DEPTH-1:0] avg;
  logic [AUDIO_DEPTH-1:0] sample_q, sample_d;
  logic [AUDIO_DEPTH-1:0] shifted;
  logic                   strobe_q, strobe_d;
  logic                   bclk_q, bclk_d;
  logic                   lrclk_q, lrclk_d;
  logic                   sdata_q, sdata_d;
  logic                   last;
  logic [5:0]             bidx;
  logic [5:0]             pos;

  // Frame counter, accumulate-and-dump averager, signed conversion.
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    last     = &cnt_q;
    sum      = acc_q + AW'(mix);
    avg      = sum[AW-1:N];
    acc_d    = sum;
    sample_d = sample_q;
    strobe_d = 1'b0;
    if (last) begin
      acc_d    = '0;
      strobe_d = 1'b1;
      sample_d = enable ?
        {~avg[AUDIO_DEPTH-1], avg[AUDIO_DEPTH-2:0]} : '0;
    end
  end

  // Serialiser: bus pins decoded straight from the frame counter.
  always_comb begin
    bidx    = cnt_q[N-1:BCLK_LOG2+1];
    pos     = {1'b0, bidx[4:0]};
    bclk_d  = cnt_q[BCLK_LOG2];
    lrclk_d = bidx[5];
    shifted = sample_q >> (DW - pos);
    sdata_d = 1'b0;
    if (pos != 6'd0 && pos <= DW) begin
      sdata_d = shifted[0];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
    end
  end

  assign i2s_bclk      = bclk_q;
  assign i2s_lrclk     = lrclk_q;
  assign i2s_sdata     = sdata_q;
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_apu_i2s_tx.sv
// tb_apu_i2s_tx: random and directed stimulus, frame-average model
// feeding a scoreboard; an I2S bus decoder pops and compares.
module tb_apu_i2s_tx;

  localparam int AD   = 16;
  localparam int BL   = 0;
  localparam int N    = BL + 7;
  localparam int FR   = 1 << N;
  localparam int HALF = 1 << BL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mix = 16'h0;
  logic        enable = 1'b0;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        sample_strobe;

  int tests = 0;
  int fails = 0;

  logic [15:0] smp_q[$];
  logic [15:0] exp_q[$];
  int          edges = 0;
  logic [15:0] last_rx = 16'h0;

  always #5 clk = ~clk;

  apu_i2s_tx #(
    .AUDIO_DEPTH(AD),
    .BCLK_LOG2  (BL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mix          (mix),
    .enable       (enable),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .sample_strobe(sample_strobe)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: every FR consumed samples form one frame; the
  // frame's floor average, offset-flipped, is sent in the next frame.
  initial begin
    longint s;
    logic [15:0] w;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        smp_q.delete();
        exp_q.delete();
        exp_q.push_back(16'h0);
        edges = 0;
      end else begin
        edges++;
        smp_q.push_back(mix);
        if (smp_q.size() == FR) begin
          s = 0;
          foreach (smp_q[i]) s += longint'(smp_q[i]);
          w = enable ? (16'(s / FR) ^ 16'h8000) : 16'h0;
          exp_q.push_back(w);
          smp_q.delete();
        end
      end
    end
  end

  // Bus monitor: decode on BCLK rising edges, compare whole slots.
  initial begin
    int ridx;
    int lastrise;
    logic [31:0] bits;
    logic [15:0] cw;
    logic pb;
    ridx = 0; lastrise = -1; bits = '0; cw = '0; pb = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        ridx = 0;
        lastrise = -1;
        bits = '0;
        pb = 1'b0;
      end else begin
        chk("strobe", 32'(sample_strobe),
            32'(edges > 0 && (edges % FR) == 0));
        if (i2s_bclk && !pb) begin
          if (lastrise >= 0)
            chk("bclk_period", 32'(edges - lastrise), 32'(2 * HALF));
          lastrise = edges;
          chk("lrclk", 32'(i2s_lrclk), 32'(ridx >= 32));
          bits = {bits[30:0], i2s_sdata};
          if (ridx == 31) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL scoreboard_empty: got word %h expected none",
                       bits[30:15]);
            end else begin
              cw = exp_q.pop_front();
              last_rx = bits[30:15];
              chk("left_slot", bits, {1'b0, cw, 15'h0});
            end
          end
          if (ridx == 63)
            chk("right_slot", bits, {1'b0, cw, 15'h0});
          ridx = (ridx + 1) % 64;
        end
        pb = i2s_bclk;
      end
    end
  end

  task automatic run_const(input logic [15:0] v, input int frames);
    mix = v;
    repeat (frames * FR) @(negedge clk);
  endtask

  // Stimulus.
  initial begin
    bit got;
    rst_n = 1'b0;
    mix = 16'hFFFF;
    enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs",
          {28'h0, i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_const(16'h8000, 4);
    chk("conv_8000", 32'(last_rx), 32'h0000);
    run_const(16'hFFFF, 4);
    chk("conv_ffff", 32'(last_rx), 32'h7FFF);
    run_const(16'h0000, 4);
    chk("conv_0000", 32'(last_rx), 32'h8000);

    for (int i = 0; i < 4 * FR; i++) begin
      mix = i[0] ? 16'h2000 : 16'h0000;
      @(negedge clk);
    end
    chk("box_alt", 32'(last_rx), 32'h9000);

    run_const(16'h0000, 2);
    mix = 16'hFFFF;
    @(negedge clk);
    run_const(16'h0000, 3);

    run_const(16'h25C3, 4);
    chk("frame_a5c3", 32'(last_rx), 32'hA5C3);

    run_const(16'hFFFF, 2);
    repeat (FR / 2) @(negedge clk);
    enable = 1'b0;
    run_const(16'hFFFF, 2);
    chk("enable_off", 32'(last_rx), 32'h0000);
    enable = 1'b1;
    run_const(16'hFFFF, 4);
    chk("enable_on", 32'(last_rx), 32'h7FFF);

    for (int i = 0; i < 20 * FR; i++) begin
      mix = 16'($urandom);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      @(negedge clk);
    end
    enable = 1'b1;

    got = 1'b0;
    for (int i = 0; i < 2 * FR && !got; i++) begin
      @(negedge clk);
      got = sample_strobe;
    end
    chk("strobe_seen", 32'(got), 32'h1);
    repeat (2 * 20 * HALF + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst",
           {28'h0, i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe}, 32'h0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6 * FR; i++) begin
      mix = 16'($urandom);
      @(negedge clk);
    end
    run_const(16'h25C3, 4);
    chk("post_rst", 32'(last_rx), 32'hA5C3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
